// File: rtl/cam_sccb_init_sequencer.sv
// Camera register-init sequencer: walks an external config ROM and issues one
// SCCB register write per entry through a req/ack transaction port. Supports
// timed delay entries, an early end marker, bounded NACK retries with error
// reporting, software restart and done/busy/progress status.
module cam_sccb_init_sequencer #(
  parameter logic [7:0] DEV_ADDR   = 8'h42,
  parameter int         N_ENTRIES  = 73,
  parameter int         IDX_W      = 7,
  parameter logic [7:0] DELAY_CODE = 8'hFF,
  parameter int         CLK_PER_MS = 1000,
  parameter int         MAX_RETRY  = 3,
  parameter bit         AUTO_START = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [IDX_W-1:0] rom_addr,
  input  logic [15:0]      rom_data,
  output logic             txn_valid,
  input  logic             txn_ready,
  output logic [7:0]       txn_dev,
  output logic [7:0]       txn_reg,
  output logic [7:0]       txn_val,
  input  logic             txn_done,
  input  logic             txn_nack,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] err_index,
  output logic [IDX_W-1:0] entries_ok
);

  localparam int              RTRY_W    = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRIES - 1);
  localparam logic [23:0]     CYC_LAST  = 24'(CLK_PER_MS - 1);
  localparam logic [RTRY_W-1:0] RTRY_MAX = RTRY_W'(MAX_RETRY);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_ISSUE  = 4'd3,
    S_WAIT   = 4'd4,
    S_DELAY  = 4'd5,
    S_NEXT   = 4'd6,
    S_DONE   = 4'd7,
    S_ERR    = 4'd8
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [IDX_W-1:0]    r_index;
  logic [15:0]         r_data;
  logic [RTRY_W-1:0]   r_retry;
  logic [23:0]         r_ms_cnt;
  logic [23:0]         r_cyc_cnt;
  logic [IDX_W-1:0]    r_entries_ok;
  logic [IDX_W-1:0]    r_err_index;
  logic                r_done;
  logic                r_error;
  logic                r_busy;
  logic                r_txn_valid;
  logic                r_auto;

  logic                w_clear;
  logic                w_latch;
  logic                w_load_delay;
  logic                w_retry_inc;
  logic                w_idx_inc;
  logic                w_next_busy;

  assign rom_addr   = r_index;
  assign txn_valid  = r_txn_valid;
  assign txn_dev    = DEV_ADDR;
  assign txn_reg    = r_data[15:8];
  assign txn_val    = r_data[7:0];
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;
  assign err_index  = r_err_index;
  assign entries_ok = r_entries_ok;

  // State register; the reset pulls everything back to IDLE at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode and datapath control strobes.
  always_comb begin
    w_next_state = r_state;
    w_clear      = 1'b0;
    w_latch      = 1'b0;
    w_load_delay = 1'b0;
    w_retry_inc  = 1'b0;
    w_idx_inc    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start || r_auto) begin
          w_clear      = 1'b1;
          w_next_state = S_FETCH;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_FETCH: begin
        w_latch      = 1'b1;
        w_next_state = S_DECODE;
      end
      S_DECODE: begin
        if (r_data[15:8] == DELAY_CODE) begin
          if (r_data[7:0] == 8'hFF) begin
            w_next_state = S_DONE;
          end else if (r_data[7:0] == 8'h00) begin
            w_next_state = S_NEXT;
          end else begin
            w_load_delay = 1'b1;
            w_next_state = S_DELAY;
          end
        end else begin
          w_next_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (r_txn_valid && txn_ready) begin
          w_next_state = S_WAIT;
        end else begin
          w_next_state = S_ISSUE;
        end
      end
      S_WAIT: begin
        if (txn_done) begin
          if (!txn_nack) begin
            w_next_state = S_NEXT;
          end else if (r_retry < RTRY_MAX) begin
            w_retry_inc  = 1'b1;
            w_next_state = S_ISSUE;
          end else begin
            w_next_state = S_ERR;
          end
        end else begin
          w_next_state = S_WAIT;
        end
      end
      S_DELAY: begin
        if ((r_cyc_cnt == CYC_LAST) && (r_ms_cnt == 24'd1)) begin
          w_next_state = S_NEXT;
        end else begin
          w_next_state = S_DELAY;
        end
      end
      S_NEXT: begin
        if (r_index == LAST_IDX) begin
          w_next_state = S_DONE;
        end else begin
          w_idx_inc    = 1'b1;
          w_next_state = S_FETCH;
        end
      end
      S_DONE, S_ERR: begin
        if (start) begin
          w_clear      = 1'b1;
          w_next_state = S_FETCH;
        end else begin
          w_next_state = r_state;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Busy is high in every state that is actively walking the table.
  always_comb begin
    w_next_busy = 1'b1;
    case (w_next_state)
      S_IDLE, S_DONE, S_ERR: w_next_busy = 1'b0;
      default:               w_next_busy = 1'b1;
    endcase
  end

  // Registered status and transaction outputs, aligned with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy      <= 1'b0;
      r_txn_valid <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_err_index <= {IDX_W{1'b0}};
      r_auto      <= AUTO_START;
    end else begin
      r_busy      <= w_next_busy;
      r_txn_valid <= (w_next_state == S_ISSUE);
      if (w_clear) begin
        r_auto      <= 1'b0;
        r_done      <= 1'b0;
        r_error     <= 1'b0;
        r_err_index <= {IDX_W{1'b0}};
      end else begin
        if (w_next_state == S_DONE) begin
          r_done <= 1'b1;
        end
        if ((w_next_state == S_ERR) && (r_state != S_ERR)) begin
          r_error     <= 1'b1;
          r_err_index <= r_index;
        end
      end
    end
  end

  // Table walk: index, entry latch, retry count and progress counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_index      <= {IDX_W{1'b0}};
      r_data       <= 16'h0000;
      r_retry      <= {RTRY_W{1'b0}};
      r_entries_ok <= {IDX_W{1'b0}};
    end else if (w_clear) begin
      r_index      <= {IDX_W{1'b0}};
      r_retry      <= {RTRY_W{1'b0}};
      r_entries_ok <= {IDX_W{1'b0}};
    end else begin
      if (w_latch) begin
        r_data <= rom_data;
      end
      if (w_retry_inc) begin
        r_retry <= r_retry + {{(RTRY_W-1){1'b0}}, 1'b1};
      end
      if (r_state == S_NEXT) begin
        r_entries_ok <= r_entries_ok + {{(IDX_W-1){1'b0}}, 1'b1};
        r_retry      <= {RTRY_W{1'b0}};
      end
      if (w_idx_inc) begin
        r_index <= r_index + {{(IDX_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Delay timer: cycle counter wraps every millisecond, ms counter counts down.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ms_cnt  <= 24'd0;
      r_cyc_cnt <= 24'd0;
    end else if (w_load_delay) begin
      r_ms_cnt  <= {16'd0, r_data[7:0]};
      r_cyc_cnt <= 24'd0;
    end else if (r_state == S_DELAY) begin
      if (r_cyc_cnt == CYC_LAST) begin
        r_cyc_cnt <= 24'd0;
        r_ms_cnt  <= r_ms_cnt - 24'd1;
      end else begin
        r_cyc_cnt <= r_cyc_cnt + 24'd1;
      end
    end
  end

endmodule
